// File: rtl/enc8_3_rr_pkg.sv
// ============================================================================
//  Module  : enc_pkg
//  Brief   : Shared widths, vector types and state encoding for enc8_3_rr.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package enc_pkg;

    localparam int ENC_N     = 8;
    localparam int ENC_IDX_W = 3;

    typedef logic [ENC_IDX_W-1:0] enc_idx_t;
    typedef logic [ENC_N-1:0]     enc_vec_t;

    // EMPTY/HOLD is exactly grant_valid, so the encoding is one bit wide.
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } enc_state_t;

endpackage : enc_pkg

`default_nettype wire

// File: rtl/enc8_3_rr_if.sv
// ============================================================================
//  Module  : enc8_3_rr_if
//  Brief   : Request/grant handshake bundle between requesters and enc8_3_rr.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface enc8_3_rr_if #(
    parameter int N     = enc_pkg::ENC_N,
    parameter int IDX_W = $clog2(N)
);

    logic [N-1:0]     req;
    logic             grant_ready;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic [N-1:0]     grant_onehot;
    logic [IDX_W-1:0] rr_ptr;

    modport master (
        output req,
        output grant_ready,
        input  grant_valid,
        input  grant_idx,
        input  grant_onehot,
        input  rr_ptr
    );

    modport slave (
        input  req,
        input  grant_ready,
        output grant_valid,
        output grant_idx,
        output grant_onehot,
        output rr_ptr
    );

endinterface : enc8_3_rr_if

`default_nettype wire

// File: rtl/enc8_3_rr_pick.sv
// ============================================================================
//  Module  : rr_pick
//  Brief   : Combinational wrap-around first-set scan of req starting at i_start.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N     = enc_pkg::ENC_N,
    parameter int IDX_W = $clog2(N)
) (
    input  wire logic [N-1:0]     i_req,
    input  wire logic [IDX_W-1:0] i_start,
    output logic      [IDX_W-1:0] o_idx,
    output logic                  o_found
);

    logic [2*N-1:0] w_mask;
    logic [2*N-1:0] w_dbl;

    // Upper copy supplies the wrapped part of the search; lower copy is masked
    // below the start, so the lowest set bit is the next requester from i_start.
    assign w_mask  = {(2*N){1'b1}} << i_start;
    assign w_dbl   = {i_req, i_req} & w_mask;
    assign o_found = |i_req;

    always_comb begin
        o_idx = '0;
        for (int j = 2*N-1; j >= 0; j--) begin
            if (w_dbl[j]) begin
                o_idx = IDX_W'(j);
            end
        end
    end

endmodule : rr_pick

`default_nettype wire

// File: rtl/enc8_3_rr.sv
// ============================================================================
//  Module  : enc8_3_rr
//  Brief   : Round-robin N-to-log2(N) request encoder with registered grant and
//            valid/ready handshake. ENC8_3_FIXED_PRI_EN selects fixed priority.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module enc8_3_rr
    import enc_pkg::*;
#(
    parameter int N     = ENC_N,
    parameter int IDX_W = $clog2(N)
) (
    input  wire logic  clk,
    input  wire logic  reset,
    enc8_3_rr_if.slave bus
);

    enc_state_t       r_state;
    enc_state_t       w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [N-1:0]     r_onehot;
    logic [N-1:0]     w_onehot_nxt;

    logic             w_valid;
    logic             w_accept;
    logic             w_load;
    logic [IDX_W-1:0] w_start;
    logic [IDX_W-1:0] w_win;
    logic             w_found;

    assign w_valid  = (r_state == ST_HOLD);
    assign w_accept = w_valid & bus.grant_ready;
    assign w_load   = ~w_valid | bus.grant_ready;

`ifdef ENC8_3_FIXED_PRI_EN
    assign w_start    = '0;
    assign bus.rr_ptr = '0;
`else
    logic [IDX_W-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= r_idx + IDX_W'(1);
        end
    end

    // The just-accepted index moves to the back of the queue immediately,
    // without waiting for r_ptr to catch up.
    assign w_start    = w_accept ? (r_idx + IDX_W'(1)) : r_ptr;
    assign bus.rr_ptr = r_ptr;
`endif

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req   (bus.req),
        .i_start (w_start),
        .o_idx   (w_win),
        .o_found (w_found)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_onehot_nxt = r_onehot;
        if (w_load) begin
            if (w_found) begin
                w_state_nxt         = ST_HOLD;
                w_idx_nxt           = w_win;
                w_onehot_nxt        = '0;
                w_onehot_nxt[w_win] = 1'b1;
            end else begin
                w_state_nxt  = ST_EMPTY;
                w_onehot_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_EMPTY;
            r_idx    <= '0;
            r_onehot <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_onehot <= w_onehot_nxt;
        end
    end

    assign bus.grant_valid  = w_valid;
    assign bus.grant_idx    = r_idx;
    assign bus.grant_onehot = r_onehot;

endmodule : enc8_3_rr

`default_nettype wire

// File: tb/tb_enc8_3_rr.sv
// ============================================================================
//  Module  : tb_enc8_3_rr
//  Brief   : Scoreboard bench for enc8_3_rr against a behavioural arbiter model.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_enc8_3_rr;

    typedef struct packed {
        logic       v;
        logic [2:0] idx;
        logic [7:0] oh;
        logic [2:0] ptr;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    exp_t sb[$];

    logic       m_valid;
    logic [2:0] m_idx;
    logic [7:0] m_oh;
    logic [2:0] m_ptr;

    enc8_3_rr_if bus ();

    enc8_3_rr u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arbiter: straightforward modular scan, updates model state.
    task automatic model_step(input logic [7:0] r, input logic rdy, input logic rst);
        logic       acc;
        logic       ld;
        logic [2:0] s;
        logic [2:0] w;
        logic       f;
        if (rst) begin
            m_valid = 1'b0; m_idx = '0; m_oh = '0; m_ptr = '0;
            return;
        end
        acc = m_valid & rdy;
        ld  = ~m_valid | rdy;
`ifdef ENC8_3_FIXED_PRI_EN
        s = 3'd0;
`else
        s = acc ? 3'((int'(m_idx) + 1) % 8) : m_ptr;
`endif
        f = 1'b0;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            if (!f && r[(int'(s) + i) % 8]) begin
                f = 1'b1;
                w = 3'((int'(s) + i) % 8);
            end
        end
`ifndef ENC8_3_FIXED_PRI_EN
        if (acc) m_ptr = 3'((int'(m_idx) + 1) % 8);
`endif
        if (ld) begin
            if (f) begin
                m_valid = 1'b1; m_idx = w; m_oh = 8'(1) << w;
            end else begin
                m_valid = 1'b0; m_oh = '0;
            end
        end
    endtask

    task automatic step(input logic [7:0] r, input logic rdy, input logic rst);
        exp_t e;
        bus.req         = r;
        bus.grant_ready = rdy;
        reset           = rst;
        model_step(r, rdy, rst);
        sb.push_back('{v: m_valid, idx: m_idx, oh: m_oh, ptr: m_ptr});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_val("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_val("valid",  32'(bus.grant_valid),  32'(e.v));
            check_val("onehot", 32'(bus.grant_onehot), 32'(e.oh));
            check_val("ptr",    32'(bus.rr_ptr),       32'(e.ptr));
            if (e.v) check_val("idx", 32'(bus.grant_idx), 32'(e.idx));
        end
        check_val("invariant", 32'(bus.grant_onehot),
                  bus.grant_valid ? (32'd1 << bus.grant_idx) : 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_valid = 1'b0; m_idx = '0; m_oh = '0; m_ptr = '0;
        bus.req = '0; bus.grant_ready = 1'b0; reset = 1'b1;

        step(8'h00, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b1);
        check_val("rst_idx", 32'(bus.grant_idx), 32'd0);

        // Reset while holding idx 5, with all requests pending.
        step(8'h20, 1'b1, 1'b0);
        check_val("hold5", 32'(bus.grant_idx), 32'd5);
        step(8'hFF, 1'b0, 1'b1);
        step(8'hFF, 1'b1, 1'b1);
        check_val("rst_hold_v", 32'(bus.grant_valid), 32'd0);

        // Round-robin sweep.
        for (int k = 0; k < 10; k++) begin
            step(8'hFF, 1'b1, 1'b0);
`ifndef ENC8_3_FIXED_PRI_EN
            check_val("sweep_idx", 32'(bus.grant_idx), 32'(k % 8));
`else
            check_val("fixed_idx", 32'(bus.grant_idx), 32'd0);
            check_val("fixed_ptr", 32'(bus.rr_ptr), 32'd0);
`endif
        end
        step(8'h00, 1'b1, 1'b0);

        // Stall: grant frozen while ready is low, even after req drops.
        step(8'b0010_0100, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step((k < 2) ? 8'b0010_0100 : 8'h00, 1'b0, 1'b0);
`ifndef ENC8_3_FIXED_PRI_EN
            check_val("stall_idx", 32'(bus.grant_idx), 32'd2);
`endif
        end
        step(8'h00, 1'b1, 1'b0);
`ifndef ENC8_3_FIXED_PRI_EN
        check_val("stall_ptr", 32'(bus.rr_ptr), 32'd3);
`endif

        // Wrap-around from 7 to 0.
        step(8'h40, 1'b1, 1'b0);
        step(8'b1000_0001, 1'b1, 1'b0);
        step(8'b1000_0001, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);
`ifndef ENC8_3_FIXED_PRI_EN
        check_val("wrap_ptr", 32'(bus.rr_ptr), 32'd1);
`endif

        // Sole requester, then two alternating requesters.
        for (int k = 0; k < 4; k++) step(8'b0000_1000, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(8'b0001_1000, 1'b1, 1'b0);
`ifndef ENC8_3_FIXED_PRI_EN
            check_val("alt_idx", 32'(bus.grant_idx), (k % 2 == 0) ? 32'd4 : 32'd3);
`endif
        end

        // Ready while empty must not move the pointer.
        for (int k = 0; k < 3; k++) step(8'h00, 1'b1, 1'b0);

        // Random traffic with occasional reset.
        for (int k = 0; k < 400; k++) begin
            step(8'($urandom & $urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 59) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_enc8_3_rr

`default_nettype wire

// File: doc/enc8_3_rr.md
Name: enc8_3_rr

Overview:
- Round-robin 8-to-3 request encoder: reduces 8 request lines to one registered 3-bit winner index plus its one-hot grant, under a valid/ready handshake.
- It is the inverse of the write-enable decoder. Decoder: index to one-hot enable. This block: request vector to index.
- Sits in front of shared resources (register-file write port, forwarding/hazard sources) where several pipeline stages contend and one index must be issued per cycle.

Parameters:
- N, 8, number of request lines (power of 2, 2..16).
- IDX_W, $clog2(N), width of the winner index (3 at default).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  N  request lines, bit i = requester i; level-sensitive.
- grant_ready  input  1  consumer accepts the current grant this cycle.
- grant_valid  output  1  grant_idx/grant_onehot hold a valid winner.
- grant_idx  output  IDX_W  registered winner index.
- grant_onehot  output  N  registered one-hot of grant_idx; all-zero when grant_valid=0.
- rr_ptr  output  IDX_W  current round-robin search start (debug/observability).

Behaviour:
- Reset, on a rising clk edge with reset=1:
  - grant_valid=0, grant_idx=0, grant_onehot=0, rr_ptr=0.
  - reset wins over every other event; an outstanding grant is dropped with no acceptance.
- States, held implicitly in grant_valid:
  - EMPTY (grant_valid=0): no grant outstanding.
  - HOLD (grant_valid=1): grant outstanding.
- accept = grant_valid & grant_ready.
- load = ~grant_valid | grant_ready. Output registers update only when load=1.
- search start s = accept ? (grant_idx+1) mod N : rr_ptr.
- Winner = first i with req[i]=1, scanning s, s+1, ..., s+N-1 mod N (wrap-around).
- On a load cycle with any req bit set:
  - grant_valid<=1, grant_idx<=winner, grant_onehot<=1<<winner.
  - Transitions EMPTY->HOLD, or HOLD->HOLD back-to-back.
- On a load cycle with req==0:
  - grant_valid<=0, grant_onehot<=0, grant_idx holds its value.
  - Transitions EMPTY->EMPTY or HOLD->EMPTY.
- HOLD with grant_ready=0: all outputs frozen. Later req changes, including the held winner dropping its req, do not disturb the grant.
- rr_ptr <= (grant_idx+1) mod N on every accept. Otherwise it holds.
- Latency:
  - req sampled at edge k appears on grant_* after edge k.
  - Full throughput: one grant per cycle while grant_ready=1 and req!=0.
- Fairness: with all N requests held high and grant_ready=1, indices are issued 0,1,...,N-1,0,... (no starvation; any held request is granted within N accepts).
- Boundaries:
  - Requester i whose req is still high on its own accept cycle is re-granted only if it is the sole requester.
  - Wrap from index N-1 to 0 in both the search and rr_ptr.
  - grant_ready while EMPTY is ignored.
  - Invariant: grant_onehot == (grant_valid ? 1<<grant_idx : 0) on every cycle.

Optional Feature:
- Macro: ENC8_3_FIXED_PRI_EN.
- Defined:
  - search start s is forced to 0, so the lowest index always wins (fixed priority).
  - rr_ptr is tied to 0; the pointer register is not built.
- Undefined: round-robin behaviour exactly as in Behaviour.
- Handshake, reset and latency are identical in both builds.

Decomposition:
- Shared package enc_pkg:
  - constants ENC_N=8, ENC_IDX_W=3.
  - typedef enc_idx_t (logic [ENC_IDX_W-1:0]).
  - typedef enc_vec_t (logic [ENC_N-1:0]).
- One sub-module, rr_pick: purely combinational. Takes req and s; returns winner index and a found flag.
  - Implemented as a double-width (2N) lowest-set-bit scan of the rotated vector.
  - Reused unchanged by the fixed-priority build with s=0.
- Top-level holds only the output/pointer registers and the load/accept logic.

Test Plan:
- Reset mid-HOLD: reset=1 while grant_valid=1, grant_idx=5 -> next cycle grant_valid=0, grant_onehot=0, rr_ptr=0; with reset still high and req=8'hFF, no grant is issued.
- Round-robin sweep: req=8'hFF, grant_ready=1 held 10 cycles -> grant_idx sequence 0,1,2,3,4,5,6,7,0,1; grant_onehot 01,02,04,...,80,01,02; grant_valid continuously 1.
- Stall: req=8'b0010_0100, grant_ready=0 -> grant_idx=2 frozen for 5 cycles even after req becomes 8'h00; raise grant_ready -> idx 2 accepted, next cycle grant_valid=0, rr_ptr=3.
- Wrap-around: rr_ptr=7 (after accepting idx 6), req=8'b1000_0001 -> grant idx 7, then idx 0, rr_ptr returns to 1.
- Sole requester re-grant vs. fairness: req=8'b0000_1000 held with grant_ready=1 -> idx 3 every cycle; then req=8'b0001_1000 -> grants alternate 4,3,4,3.
- Fixed-priority build (ENC8_3_FIXED_PRI_EN defined): req=8'hFF, grant_ready=1 -> grant_idx=0 every cycle, rr_ptr=0 throughout.
